div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider used by the execute stage for DIV/DIVU.
- The EX stage drives operands and a start request. It holds the pipeline stalled until this block raises ready_o, then writes result_o into HI (remainder) and LO (quotient).
- Takes one quotient bit per cycle. Supports signed and unsigned operation, divide-by-zero short-cut, and annul on pipeline flush.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- signed_div_i  in  1  1 = signed division (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  division request; held high by EX until ready_o is seen.
- annul_i  in  1  cancel any in-progress division (flush/exception).
- result_o  out  2*DATA_W  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  out  1  result_o valid.

Behaviour:
- Reset and outputs:
  - Reset (rst=1 at an edge, any state, including mid-division): state FREE, cnt=0, result_o=0, ready_o=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0, divisor==0 → BYZERO.
  - start_i=1 and annul_i=0, divisor!=0 → ON. On the same edge:
    - latch operands as magnitudes (two's-complement negate if signed_div_i=1 and MSB set);
    - latch signed_div_i and both operand sign bits;
    - cnt=0; load working register {DATA_W+1 zero bits, |dividend|}.
  - start_i=1 with annul_i=1 → stay FREE.
- BYZERO: next edge → END with result_o=0, ready_o=1.
- ON:
  - annul_i=1 → FREE, ready_o=0, result_o=0, cnt=0.
  - cnt<DATA_W: one iteration per edge.
    - Shift working register left by 1.
    - Trial-subtract divisor from the upper DATA_W+1 bits.
    - If non-negative, keep the difference and set quotient LSB=1; else restore and set LSB=0.
    - cnt++.
  - cnt==DATA_W: apply sign fix-up, register result_o, ready_o=1, → END.
    - Quotient is negated if signed and operand signs differ.
    - Remainder is negated if signed and dividend was negative.
- END:
  - ready_o=1 and result_o held while start_i=1.
  - start_i=0 → FREE, ready_o=0, result_o=0.
  - annul_i in END has no effect; the result is already produced.
- Latency: start sampled at edge k (FREE→ON); iterations on edges k+1..k+DATA_W; ready_o=1 after edge k+DATA_W+1 (33 edges for DATA_W=32). Divide-by-zero: ready_o=1 after edge k+1.
- Operand changes after the start edge are ignored; operands are sampled once.
- Arithmetic wraps at DATA_W: signed 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- ready_o is never high in FREE, ON or BYZERO.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held → ready_o rises exactly 33 edges after the start edge; result_o=64'h00000002_0000000E; drop start → next cycle ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → result_o=64'hFFFFFFFF_FFFFFFFD. Signed 7/-2 → 64'h00000001_FFFFFFFD. Signed 0x80000000/0xFFFFFFFF → 64'h00000000_80000000.
- Unsigned 0xFFFFFFFF/1 → 64'h00000000_FFFFFFFF; unsigned 5/0 → ready_o=1 two edges after start, result_o=0.
- Start 1000/3, assert annul_i for one cycle at iteration 10 → next cycle FREE, ready_o stays 0 (check 40 cycles). Then start 9/4 → 64'h00000001_00000002 after 33 edges.
- Assert rst at iteration 20 → outputs 0, state FREE. Then a fresh 50/5 → 64'h00000000_0000000A. Also start_i=1 with annul_i=1 in FREE → no division begins.
- Hold start_i high 5 cycles past ready → result_o stable and ready_o=1 throughout. Change operands during ON → result still reflects the operands sampled at the start edge.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake between the execute stage and the multi-cycle divider.
interface div_unit_if #(
   parameter int unsigned DATA_W = 32
);
   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   // EX stage side: drives operands and the request, consumes the result
   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   // Divider side
   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient}, divide-by-zero short-cut and flush annul.
module div_unit #(
   parameter int unsigned DATA_W = 32
) (
   input logic        clk,
   input logic        rst,
   div_unit_if.slave  bus
);

   localparam int unsigned CntW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [2*DATA_W:0]     work_q, work_d;
   logic [DATA_W-1:0]     divisor_q, divisor_d;
   logic                  signed_q, signed_d;
   logic                  sign1_q, sign1_d;
   logic                  sign2_q, sign2_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;

   logic [DATA_W-1:0]     mag1, mag2;
   logic [DATA_W-1:0]     quo_fix, rem_fix;
   logic [2*DATA_W+1:0]   shifted;
   logic [DATA_W:0]       diff;
   logic                  trial_ok;

   // Operand magnitudes, trial subtraction and final sign fix-up
   always_comb begin
      mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
      mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
      shifted  = {work_q, 1'b0};
      // Compare on the full shifted upper part so no borrow bit is needed
      trial_ok = shifted[2*DATA_W+1:DATA_W] >= {2'b00, divisor_q};
      diff     = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
      quo_fix  = (signed_q && (sign1_q ^ sign2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
      rem_fix  = (signed_q && sign1_q) ? -work_q[2*DATA_W-1:DATA_W]
                                       : work_q[2*DATA_W-1:DATA_W];
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      signed_d  = signed_q;
      sign1_d   = sign1_q;
      sign2_d   = sign2_q;
      result_d  = result_q;
      ready_d   = ready_q;
      unique case (state_q)
         StFree: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_d = StByZero;
               end else begin
                  state_d   = StOn;
                  divisor_d = mag2;
                  signed_d  = bus.signed_div_i;
                  sign1_d   = bus.opdata1_i[DATA_W-1];
                  sign2_d   = bus.opdata2_i[DATA_W-1];
                  cnt_d     = '0;
                  work_d    = {{(DATA_W + 1){1'b0}}, mag1};
               end
            end
         end
         StByZero: begin
            state_d  = StEnd;
            result_d = '0;
            ready_d  = 1'b1;
         end
         StOn: begin
            if (bus.annul_i) begin
               state_d  = StFree;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q != CntW'(DATA_W)) begin
               work_d = trial_ok ? {diff, shifted[DATA_W-1:1], 1'b1} : shifted[2*DATA_W:0];
               cnt_d  = cnt_q + 1'b1;
            end else begin
               state_d  = StEnd;
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
            end
         end
         StEnd: begin
            // Annul is ignored here: the result has already been produced
            if (!bus.start_i) begin
               state_d  = StFree;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: state_d = StFree;
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         signed_q  <= 1'b0;
         sign1_q   <= 1'b0;
         sign2_q   <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         signed_q  <= signed_d;
         sign1_q   <= sign1_d;
         sign2_q   <= sign2_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule
